// File: rtl/spram_bist_ctrl.sv
// Single-port RAM write/read-back self-test controller.
// Owns an inferred single-port RAM. On start it fills DEPTH words with a
// pattern, reads them all back, compares each word and reports the result.
// Ports:
//   sys_clk, sys_rst_n        clock (rising edge), async active-low reset
//   start, mode, seed,        test request and pattern controls; the controls
//   inject_err                  are latched only when a start is accepted
//   busy, done, pass          status: busy for the whole test, done pulse, result
//   err_cnt, first_err_addr   mismatch count and address of the first mismatch
//   ram_rd_data               RAM read data, RD_LAT cycles after the address
module spram_bist_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] ram_rd_data
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX    = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          drain_q, drain_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic                inj_q, inj_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic [1:0]          vld_q, vld_d;
  logic [ADDR_W-1:0]   cmp_addr0_q, cmp_addr0_d, cmp_addr1_q, cmp_addr1_d;

  logic                wren_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                cmp_vld_c;
  logic [ADDR_W-1:0]   cmp_addr_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                mismatch_c;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  // Expected word for an address: (addr + seed) mod 2**DATA_W, optionally inverted.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic m,
                                                input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = DATA_W'(a) + s;
    return m ? ~v : v;
  endfunction

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    inj_d       = inj_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    rd1_d       = mem[addr_q];
    rd2_d       = rd1_q;
    vld_d       = {vld_q[0], (state_q == S_READ)};
    cmp_addr0_d = addr_q;
    cmp_addr1_d = cmp_addr0_q;

    wren_c  = (state_q == S_WRITE);
    wdata_c = pattern(addr_q, mode_q, seed_q) ^
              DATA_W'(inj_q && (32'(addr_q) == 32'd3));

    // Compare stage sits RD_LAT cycles behind the read address.
    cmp_vld_c  = (RD_LAT == 2) ? vld_q[1]    : vld_q[0];
    cmp_addr_c = (RD_LAT == 2) ? cmp_addr1_q : cmp_addr0_q;
    rd_data_c  = (RD_LAT == 2) ? rd2_q       : rd1_q;
    mismatch_c = cmp_vld_c && (rd_data_c != pattern(cmp_addr_c, mode_q, seed_q));

    if (mismatch_c) begin
      if (err_cnt_q == '0)      first_err_d = cmp_addr_c;
      if (err_cnt_q != ERR_MAX) err_cnt_d   = err_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          mode_d      = mode;
          seed_d      = seed;
          inj_d       = inject_err;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          // Last compare lands in this cycle, so judge on the updated count.
          pass_d  = (err_cnt_d == '0);
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      drain_q     <= '0;
      mode_q      <= 1'b0;
      seed_q      <= '0;
      inj_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      vld_q       <= '0;
      cmp_addr0_q <= '0;
      cmp_addr1_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      inj_q       <= inj_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      vld_q       <= vld_d;
      cmp_addr0_q <= cmp_addr0_d;
      cmp_addr1_q <= cmp_addr1_d;
    end
  end

  // RAM array: contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (wren_c) mem[addr_q] <= wdata_c;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign ram_rd_data    = rd_data_c;

endmodule
